// File: rtl/ifmap_fifo_sched.sv
// ifmap_fifo_sched: round-robin refill of byte-wide ifmap FIFOs from GLB.
// Optional ARB stall counter: define IFMAP_FIFO_SCHED_PERF_EN.
module ifmap_fifo_sched #(
    parameter int NUM_FIFO = 4,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   fifo_stride,
    input  logic [CNT_W-1:0]    word_cnt,
    output logic                busy,
    output logic                done,
    output logic                glb_rd_en,
    output logic [ADDR_W-1:0]   glb_rd_addr,
    input  logic [31:0]         glb_rd_data,
    input  logic [NUM_FIFO-1:0] fifo_empty,
    output logic [NUM_FIFO-1:0] fifo_push_en,
    output logic                fifo_push_mod,
    output logic [31:0]         fifo_push_data,
    output logic [31:0]         perf_stall_cnt
);

    localparam int SEL_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        REQ,
        WAIT,
        PUSH,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] next_addr;
    logic [CNT_W-1:0]  rem_q  [NUM_FIFO];
    logic [CNT_W-1:0]  widx_q [NUM_FIFO];
    logic [SEL_W-1:0]  rr_q;
    logic [SEL_W-1:0]  rr_next;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  pick_idx;
    logic [31:0]       data_q;

    logic [NUM_FIFO-1:0] elig;
    logic                all_done;
    logic                pick_vld;
    logic                start_ok;
    logic                take;

    assign start_ok = (state_q == IDLE) && start;
    assign take     = (state_q == ARB) && !all_done && pick_vld;

    // A FIFO is eligible when it is empty and still owed words.
    always_comb begin
        all_done = 1'b1;
        elig     = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            elig[i] = fifo_empty[i] && (rem_q[i] != '0);
            if (rem_q[i] != '0) begin
                all_done = 1'b0;
            end
        end
    end

    // Circular search from rr_q; walking backwards leaves the first hit.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_FIFO - 1; k >= 0; k--) begin
            j = int'(rr_q) + k;
            if (j >= NUM_FIFO) begin
                j = j - NUM_FIFO;
            end
            if (elig[SEL_W'(j)]) begin
                pick_vld = 1'b1;
                pick_idx = SEL_W'(j);
            end
        end
    end

    assign next_addr = base_q
                     + ADDR_W'(pick_idx) * stride_q
                     + (ADDR_W'(widx_q[pick_idx]) << 2);

    assign rr_next = (sel_q == SEL_W'(NUM_FIFO - 1))
                   ? '0 : sel_q + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and strobes; a zero quota drains through ARB to DONE.
    always_comb begin
        state_d      = state_q;
        glb_rd_en    = 1'b0;
        fifo_push_en = '0;
        done         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (all_done) begin
                    state_d = DONE;
                end else if (pick_vld) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                glb_rd_en = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                state_d = PUSH;
            end
            PUSH: begin
                fifo_push_en[sel_q] = 1'b1;
                state_d             = ARB;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Job registers, per-FIFO quotas, selected FIFO and data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            stride_q <= '0;
            addr_q   <= '0;
            rr_q     <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            for (int i = 0; i < NUM_FIFO; i++) begin
                rem_q[i]  <= '0;
                widx_q[i] <= '0;
            end
        end else begin
            if (start_ok) begin
                base_q   <= base_addr;
                stride_q <= fifo_stride;
                rr_q     <= '0;
                for (int i = 0; i < NUM_FIFO; i++) begin
                    rem_q[i]  <= word_cnt;
                    widx_q[i] <= '0;
                end
            end
            if (take) begin
                sel_q  <= pick_idx;
                addr_q <= next_addr;
            end
            if (state_q == WAIT) begin
                data_q <= glb_rd_data;
            end
            if (state_q == PUSH) begin
                rem_q[sel_q]  <= rem_q[sel_q] - 1'b1;
                widx_q[sel_q] <= widx_q[sel_q] + 1'b1;
                rr_q          <= rr_next;
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign glb_rd_addr    = addr_q;
    assign fifo_push_data = data_q;
    assign fifo_push_mod  = 1'b1;

`ifdef IFMAP_FIFO_SCHED_PERF_EN
    logic [31:0] stall_q;
    logic        stall;

    assign stall = (state_q == ARB) && !all_done && !pick_vld;

    // Saturating count of ARB cycles with work pending but nothing eligible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (stall && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign perf_stall_cnt = stall_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ifmap_fifo_sched.sv
// tb_ifmap_fifo_sched: random and directed check of ifmap_fifo_sched.
// Transaction-timing model plus FIFO/GLB behavioural models.
module tb_ifmap_fifo_sched;

    localparam int NF = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [31:0]   fifo_stride = '0;
    logic [15:0]   word_cnt = '0;
    logic          busy;
    logic          done;
    logic          glb_rd_en;
    logic [31:0]   glb_rd_addr;
    logic [31:0]   glb_rd_data = '0;
    logic [NF-1:0] fifo_empty;
    logic [NF-1:0] fifo_push_en;
    logic          fifo_push_mod;
    logic [31:0]   fifo_push_data;
    logic [31:0]   perf_stall_cnt;

    ifmap_fifo_sched #(
        .NUM_FIFO(NF),
        .ADDR_W(32),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .fifo_stride(fifo_stride),
        .word_cnt(word_cnt),
        .busy(busy),
        .done(done),
        .glb_rd_en(glb_rd_en),
        .glb_rd_addr(glb_rd_addr),
        .glb_rd_data(glb_rd_data),
        .fifo_empty(fifo_empty),
        .fifo_push_en(fifo_push_en),
        .fifo_push_mod(fifo_push_mod),
        .fifo_push_data(fifo_push_data),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] gen(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h2B1D};
    endfunction

    // FIFO occupancy (bytes) and pop policy.
    int fcnt [NF];
    bit pop_en [NF];
    bit pop_all = 1'b1;
    int pop_prob = 100;

    always_comb begin
        for (int i = 0; i < NF; i++) begin
            fifo_empty[i] = (fcnt[i] == 0);
        end
    end

    logic          s_rd = 1'b0;
    logic [31:0]   s_addr = '0;
    logic [NF-1:0] s_push = '0;

    // GLB returns data one cycle after a read; FIFOs pop, then take pushes.
    always @(posedge clk) begin
        #1;
        glb_rd_data = s_rd ? gen(s_addr) : $urandom;
        for (int i = 0; i < NF; i++) begin
            if (pop_en[i] && fcnt[i] > 0 &&
                $urandom_range(99) < pop_prob) begin
                if (pop_all) fcnt[i] = 0;
                else fcnt[i] -= $urandom_range(1, fcnt[i] < 4 ? fcnt[i] : 4);
            end
            if (s_push[i]) fcnt[i] += 4;
        end
    end

    // Model state: when the next arbitration, read, push, done happen.
    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_arb_at = -1;
    int          m_rd_at = -1;
    int          m_push_at = -1;
    int          m_done_at = -1;
    int          m_start_cyc = 0;
    int          m_sel = 0;
    int          m_rr = 0;
    int          m_rem [NF];
    int          m_widx [NF];
    logic [31:0] m_addr = '0;
    logic [31:0] m_base = '0;
    logic [31:0] m_stride = '0;
    logic [31:0] m_stall = '0;

    logic [31:0] rd_log [$];
    int          push_log [$];
    int          done_log [$];
    int          done_cnt = 0;

    // Compare DUT against model every cycle, then advance the model.
    always @(negedge clk) begin
        logic [NF-1:0] exp_push;
        bit acc;
        bit all0;
        bit found;
        int s;
        int j;
        cyc++;
        s_rd   = glb_rd_en;
        s_addr = glb_rd_addr;
        s_push = fifo_push_en;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rd_en", glb_rd_en, 0);
            chk("rst_push_en", fifo_push_en, 0);
            chk("rst_rd_addr", glb_rd_addr, 0);
            chk("rst_push_data", fifo_push_data, 0);
            chk("rst_push_mod", fifo_push_mod, 1);
            chk("rst_perf", perf_stall_cnt, 0);
            m_busy = 0;
            m_arb_at = -1;
            m_rd_at = -1;
            m_push_at = -1;
            m_done_at = -1;
            m_stall = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("rd_en", glb_rd_en, cyc == m_rd_at);
            if (cyc == m_rd_at) chk("rd_addr", glb_rd_addr, m_addr);
            exp_push = '0;
            if (cyc == m_push_at) exp_push[m_sel] = 1'b1;
            chk("push_en", fifo_push_en, exp_push);
            if (cyc == m_push_at) begin
                chk("push_data", fifo_push_data, gen(m_addr));
                chk("push_safe", fcnt[m_sel], 0);
            end
            chk("done", done, cyc == m_done_at);
            chk("push_mod", fifo_push_mod, 1);
`ifdef IFMAP_FIFO_SCHED_PERF_EN
            chk("perf", perf_stall_cnt, m_stall);
`else
            chk("perf", perf_stall_cnt, 0);
`endif
            if (glb_rd_en) rd_log.push_back(glb_rd_addr);
            for (int i = 0; i < NF; i++)
                if (fifo_push_en[i]) push_log.push_back(i);
            if (done) begin
                done_log.push_back(cyc - m_start_cyc);
                done_cnt++;
            end
            acc = start && !m_busy;
            if (cyc == m_done_at) m_busy = 0;
            if (acc) begin
                m_busy = 1;
                m_start_cyc = cyc;
                m_base = base_addr;
                m_stride = fifo_stride;
                m_rr = 0;
                m_stall = 0;
                for (int i = 0; i < NF; i++) begin
                    m_rem[i] = int'(word_cnt);
                    m_widx[i] = 0;
                end
                m_arb_at = cyc + 1;
            end else if (cyc == m_arb_at) begin
                all0 = 1;
                for (int i = 0; i < NF; i++)
                    if (m_rem[i] != 0) all0 = 0;
                if (all0) begin
                    m_done_at = cyc + 1;
                    m_arb_at = -1;
                end else begin
                    found = 0;
                    s = 0;
                    for (int k = 0; k < NF; k++) begin
                        j = (m_rr + k) % NF;
                        if (!found && fifo_empty[j] && m_rem[j] != 0) begin
                            found = 1;
                            s = j;
                        end
                    end
                    if (found) begin
                        m_sel = s;
                        m_addr = m_base + 32'(s) * m_stride
                               + 32'(m_widx[s]) * 32'd4;
                        m_rd_at = cyc + 1;
                        m_push_at = cyc + 3;
                        m_arb_at = cyc + 4;
                        m_rem[s]--;
                        m_widx[s]++;
                        m_rr = (s + 1) % NF;
                    end else begin
                        m_arb_at = cyc + 1;
                        if (m_stall != 32'hFFFF_FFFF) m_stall++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] s,
                            input logic [15:0] c);
        base_addr = b;
        fifo_stride = s;
        word_cnt = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = $urandom;
        fifo_stride = $urandom;
        word_cnt = 16'($urandom);
    endtask

    task automatic spurious_start();
        base_addr = $urandom;
        fifo_stride = $urandom;
        word_cnt = 16'($urandom_range(1, 9));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < lim) begin
            tick();
            k++;
        end
        chk("done_timeout", done_cnt != n0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < NF; i++) pop_en[i] = 1'b1;
        pop_all = 1'b1;
        pop_prob = 100;
        repeat (3) tick();
        rd_log.delete();
        push_log.delete();
        done_log.delete();
    endtask

    function automatic logic [31:0] rdq(input int i);
        return (i < rd_log.size()) ? rd_log[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic int pq(input int i);
        return (i < push_log.size()) ? push_log[i] : -1;
    endfunction

    initial begin
        logic [31:0] exp_rd [4];
        logic [31:0] b;
        logic [31:0] s;
        for (int i = 0; i < NF; i++) begin
            fcnt[i] = 0;
            pop_en[i] = 1'b1;
        end
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic quota with an ignored start while busy.
        drain();
        do_start(32'h100, 32'h40, 16'd1);
        repeat (3) tick();
        spurious_start();
        wait_done(100);
        exp_rd[0] = 32'h100;
        exp_rd[1] = 32'h140;
        exp_rd[2] = 32'h180;
        exp_rd[3] = 32'h1C0;
        chk("basic_nrd", rd_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_rd", rdq(i), exp_rd[i]);
            chk("basic_push", pq(i), i);
        end
        chk("basic_done_lat", done_log.size() > 0 ? done_log[0] : -1, 18);

        // Zero count.
        drain();
        do_start(32'h200, 32'h10, 16'd0);
        wait_done(10);
        chk("zero_done_lat", done_log.size() > 0 ? done_log[0] : -1, 2);
        chk("zero_nrd", rd_log.size(), 0);
        chk("zero_npush", push_log.size(), 0);

        // Stall on FIFO 1, then resume.
        drain();
        pop_en[1] = 1'b0;
        do_start(32'h100, 32'h40, 16'd2);
        repeat (60) tick();
        chk("stall_nodone", done_log.size(), 0);
        chk("stall_nrd", rd_log.size(), 7);
        chk("stall_rd4", rdq(4), 32'h104);
`ifdef IFMAP_FIFO_SCHED_PERF_EN
        chk("stall_perf_grows", perf_stall_cnt > 20, 1);
`endif
        pop_en[1] = 1'b1;
        wait_done(60);
        chk("resume_nrd", rd_log.size(), 8);
        chk("resume_rd", rdq(7), 32'h144);
        chk("resume_push", pq(7), 1);

        // Round robin: FIFOs 0 and 2 freed together with rr at 1.
        drain();
        for (int i = 0; i < NF; i++) pop_en[i] = 1'b0;
        fcnt[1] = 8;
        fcnt[2] = 8;
        fcnt[3] = 8;
        do_start(32'h1000, 32'h100, 16'd2);
        repeat (12) tick();
        chk("rr_nrd_hold", rd_log.size(), 1);
        pop_en[0] = 1'b1;
        pop_en[2] = 1'b1;
        repeat (6) tick();
        chk("rr_first", rdq(0), 32'h1000);
        chk("rr_second", rdq(1), 32'h1200);
        chk("rr_push2", pq(1), 2);
        for (int i = 0; i < NF; i++) pop_en[i] = 1'b1;
        wait_done(300);

        // Reset during WAIT drops the push; restart from word 0.
        drain();
        do_start(32'h3000, 32'h20, 16'd3);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rst_nrd", rd_log.size(), 1);
        chk("rst_npush", push_log.size(), 0);
        rd_log.delete();
        do_start(32'h3000, 32'h20, 16'd3);
        wait_done(300);
        chk("restart_rd0", rdq(0), 32'h3000);
        chk("restart_nrd", rd_log.size(), 12);

        // Randomized jobs with random pop behaviour.
        for (int r = 0; r < 10; r++) begin
            drain();
            pop_all = 1'b0;
            pop_prob = $urandom_range(10, 90);
            b = $urandom & 32'hFFFF_FFFC;
            if (r % 3 == 0) s = $urandom & 32'hFFFF_FFFC;
            else s = 32'($urandom_range(0, 16384)) << 2;
            do_start(b, s, 16'($urandom_range(1, 5)));
            repeat (3) tick();
            spurious_start();
            wait_done(3000);
        end
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
